sample_accumulator: RTL and testbench

// Parametrised per-frame mixer behind the core: sums NUM_VOICES signed subsamples per output frame.

---
 rtl/sample_accumulator.sv | 190 +++++++++++++++++++
 tb/tb_sample_accumulator.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_accumulator.sv
// sample_accumulator: per-frame voice mixer. Sums NUM_VOICES signed subsamples,
// scales the sum by an arithmetic right shift, saturates to OUTPUT_WIDTH and
// queues the result in a small FIFO with a valid/ready handshake toward the
// DAC/PWM stage. Sticky flags report clipping, dropped frames and frames with
// a wrong subsample count.
// Optional feature: define SAMPLE_DITHER_EN to add LFSR-driven rounding dither
// ahead of the shift.
module sample_accumulator #(
  parameter int SUBSAMPLE_WIDTH = 16,
  parameter int NUM_VOICES      = 16,
  parameter int OUTPUT_WIDTH    = 16,
  parameter int SHIFT           = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                              i_Clock,
  input  logic                              i_Reset,
  input  logic signed [SUBSAMPLE_WIDTH-1:0] i_Subsample,
  input  logic                              i_SubsampleValid,
  input  logic                              i_FrameEnd,
  output logic signed [OUTPUT_WIDTH-1:0]    o_Sample,
  output logic                              o_SampleValid,
  input  logic                              i_SampleReady,
  output logic [$clog2(FIFO_DEPTH):0]       o_FifoLevel,
  output logic                              o_Clipped,
  output logic                              o_Overrun,
  output logic                              o_CountError,
  input  logic                              i_ClearFlags
);

  localparam int GUARD_BITS  = $clog2(NUM_VOICES) + 1;
  localparam int ACC_WIDTH   = SUBSAMPLE_WIDTH + GUARD_BITS;
  // One extra bit so adding dither to a full-scale sum cannot wrap.
  localparam int SUM_WIDTH   = ACC_WIDTH + 1;
  // Wide enough that a correct count never reaches the saturation value.
  localparam int CNT_WIDTH   = $clog2(NUM_VOICES + 1) + 1;
  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_WIDTH = ADDR_WIDTH + 1;

  localparam logic signed [SUM_WIDTH-1:0] OUT_MAX =
    {{(SUM_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] OUT_MIN =
    {{(SUM_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  // Frame accumulation state
  logic signed [ACC_WIDTH-1:0]    acc;
  logic [CNT_WIDTH-1:0]           count;

  // Frame-end datapath
  logic signed [ACC_WIDTH-1:0]    sub_ext;
  logic signed [ACC_WIDTH-1:0]    frame_final;
  logic [CNT_WIDTH:0]             count_final;
  logic signed [SUM_WIDTH-1:0]    dithered;
  logic signed [SUM_WIDTH-1:0]    scaled;
  logic signed [OUTPUT_WIDTH-1:0] saturated;
  logic                           clip_now;
  logic                           count_err_now;

  // Result register feeding the FIFO
  logic                           res_valid;
  logic signed [OUTPUT_WIDTH-1:0] res_data;

  // Output FIFO
  logic signed [OUTPUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]          wr_ptr;
  logic [ADDR_WIDTH-1:0]          rd_ptr;
  logic [LEVEL_WIDTH-1:0]         level;
  logic                           full;
  logic                           pop;
  logic                           push_ok;
  logic                           overrun_now;

`ifdef SAMPLE_DITHER_EN
  localparam logic [15:0] DITHER_MASK = 16'((1 << SHIFT) - 1);
  logic [15:0] lfsr;

  // Dither source: Fibonacci LFSR (taps 16,14,13,11), stepped once per frame.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      lfsr <= 16'hACE1;
    end else if (i_FrameEnd) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`endif

  // Frame total, scaling, saturation and per-frame error detection.
  always_comb begin
    // NOTE: every variable gets a value on every path here; a missed default would infer a latch.
    sub_ext       = {{GUARD_BITS{i_Subsample[SUBSAMPLE_WIDTH-1]}}, i_Subsample};
    frame_final   = acc + (i_SubsampleValid ? sub_ext : '0);
    count_final   = {1'b0, count} + (CNT_WIDTH+1)'(i_SubsampleValid);
`ifdef SAMPLE_DITHER_EN
    dithered      = {frame_final[ACC_WIDTH-1], frame_final} + SUM_WIDTH'(lfsr & DITHER_MASK);
`else
    dithered      = {frame_final[ACC_WIDTH-1], frame_final};
`endif
    scaled        = dithered >>> SHIFT;
    saturated     = scaled[OUTPUT_WIDTH-1:0];
    clip_now      = 1'b0;
    if (scaled > OUT_MAX) begin
      saturated = OUT_MAX[OUTPUT_WIDTH-1:0];
      clip_now  = 1'b1;
    end else if (scaled < OUT_MIN) begin
      saturated = OUT_MIN[OUTPUT_WIDTH-1:0];
      clip_now  = 1'b1;
    end
    count_err_now = (count_final != (CNT_WIDTH+1)'(NUM_VOICES));
  end

  // Accumulate subsamples; a frame end restarts the frame in the same cycle.
  always_ff @(posedge i_Clock) begin
    // NOTE: registers are assigned with <= so every flop samples pre-edge values regardless of statement order.
    if (i_Reset || i_FrameEnd) begin
      acc   <= '0;
      count <= '0;
    end else if (i_SubsampleValid) begin
      acc <= acc + sub_ext;
      if (count != '1) begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

  // Capture the finished frame one cycle after its frame end.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= i_FrameEnd;
      if (i_FrameEnd) begin
        res_data <= saturated;
      end
    end
  end

  // FIFO handshake: a push into a full queue only succeeds alongside a pop.
  always_comb begin
    full        = (level == LEVEL_WIDTH'(FIFO_DEPTH));
    pop         = (level != '0) && i_SampleReady;
    push_ok     = res_valid && (!full || pop);
    overrun_now = res_valid && full && !pop;
  end

  // FIFO storage write.
  always_ff @(posedge i_Clock) begin
    // NOTE: the storage array is deliberately not reset; level alone says which entries are meaningful.
    if (push_ok) begin
      mem[wr_ptr] <= res_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      level <= level + LEVEL_WIDTH'(push_ok) - LEVEL_WIDTH'(pop);
    end
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Clipped    <= 1'b0;
      o_Overrun    <= 1'b0;
      o_CountError <= 1'b0;
    end else begin
      o_Clipped    <= (i_FrameEnd && clip_now)      || (o_Clipped    && !i_ClearFlags);
      o_Overrun    <= overrun_now                   || (o_Overrun    && !i_ClearFlags);
      o_CountError <= (i_FrameEnd && count_err_now) || (o_CountError && !i_ClearFlags);
    end
  end

  // Head of queue; forced to zero while empty so it never shows stale storage.
  always_comb begin
    o_SampleValid = (level != '0);
    o_Sample      = o_SampleValid ? mem[rd_ptr] : '0;
    o_FifoLevel   = level;
  end

endmodule

// File: tb/tb_sample_accumulator.sv
// tb_sample_accumulator: table-driven frame vectors, hand-written sequences for
// backpressure/overrun/reset corners, and randomized frames checked every cycle
// against a queue-based reference model of the mixer and its output FIFO.
module tb_sample_accumulator;

  localparam int ACC_W = 21;
  localparam int SHIFT = 4;
  localparam int DEPTH = 4;
  localparam int NV    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, sub_v, fe, rdy, clr;
  logic signed [15:0] sub;

  logic signed [15:0] o_sample, s0_sample;
  logic               o_valid, s0_valid;
  logic [2:0]         o_level, s0_level;
  logic               o_clip, o_ovr, o_cnt;
  logic               s0_clip, s0_ovr, s0_cnt;

  sample_accumulator dut (
    .i_Clock(clk), .i_Reset(rst), .i_Subsample(sub), .i_SubsampleValid(sub_v),
    .i_FrameEnd(fe), .o_Sample(o_sample), .o_SampleValid(o_valid),
    .i_SampleReady(rdy), .o_FifoLevel(o_level), .o_Clipped(o_clip),
    .o_Overrun(o_ovr), .o_CountError(o_cnt), .i_ClearFlags(clr)
  );

  sample_accumulator #(.SHIFT(0)) dut_s0 (
    .i_Clock(clk), .i_Reset(rst), .i_Subsample(sub), .i_SubsampleValid(sub_v),
    .i_FrameEnd(fe), .o_Sample(s0_sample), .o_SampleValid(s0_valid),
    .i_SampleReady(rdy), .o_FifoLevel(s0_level), .o_Clipped(s0_clip),
    .o_Overrun(s0_ovr), .o_CountError(s0_cnt), .i_ClearFlags(clr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: subsamples of the open frame, finished frame waiting to
  // enter the queue, the queue itself, and the three sticky flags.
  int     m_frame[$];
  longint m_fifo[$];
  bit     m_pend_v = 1'b0;
  longint m_pend   = 0;
  bit     m_clip = 1'b0, m_ovr = 1'b0, m_cnt = 1'b0;

  function automatic longint mix(input int subs[$], input int shift, output bit clip);
    longint sum = 0;
    longint v;
    logic signed [ACC_W-1:0] wrapped;
    foreach (subs[i]) sum += subs[i];
    wrapped = ACC_W'(sum);
    v = wrapped;
    v = v >>> shift;
    clip = 1'b0;
    if (v > 32767)  begin v = 32767;  clip = 1'b1; end
    if (v < -32768) begin v = -32768; clip = 1'b1; end
    return v;
  endfunction

  task automatic model_step();
    bit pop, clip_set, cnt_set, ovr_set;
    clip_set = 1'b0; cnt_set = 1'b0; ovr_set = 1'b0;
    if (rst) begin
      m_frame.delete(); m_fifo.delete();
      m_pend_v = 1'b0; m_clip = 1'b0; m_ovr = 1'b0; m_cnt = 1'b0;
      return;
    end
    pop = (m_fifo.size() != 0) && rdy;
    if (pop) void'(m_fifo.pop_front());
    if (m_pend_v) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend);
      else ovr_set = 1'b1;
    end
    m_pend_v = 1'b0;
    if (fe) begin
      if (sub_v) m_frame.push_back(int'(sub));
      m_pend   = mix(m_frame, SHIFT, clip_set);
      cnt_set  = (m_frame.size() != NV);
      m_pend_v = 1'b1;
      m_frame.delete();
    end else if (sub_v) begin
      m_frame.push_back(int'(sub));
    end
    m_clip = clip_set || (m_clip && !clr);
    m_ovr  = ovr_set  || (m_ovr  && !clr);
    m_cnt  = cnt_set  || (m_cnt  && !clr);
  endtask

  // Compare the current cycle against the model, advance both one clock.
  task automatic tick();
    check("level", o_level, m_fifo.size());
    check("valid", o_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) check("head", o_sample, m_fifo[0]);
    check("clipped", o_clip, m_clip);
    check("overrun", o_ovr, m_ovr);
    check("count_err", o_cnt, m_cnt);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  // n subsamples, frame end on the last one or in a separate cycle after.
  // rdy_pct < 0 leaves ready untouched.
  task automatic run_frame(input int n, input bit fe_sep, input bit rnd_val,
                           input int val, input int rdy_pct);
    for (int i = 0; i < n; i++) begin
      sub   = rnd_val ? 16'($urandom) : 16'(val);
      sub_v = 1'b1;
      fe    = !fe_sep && (i == n - 1);
      if (rdy_pct >= 0) rdy = (int'($urandom_range(0, 99)) < rdy_pct);
      tick();
    end
    if (fe_sep) begin
      sub_v = 1'b0; fe = 1'b1;
      if (rdy_pct >= 0) rdy = (int'($urandom_range(0, 99)) < rdy_pct);
      tick();
    end
    sub_v = 1'b0; fe = 1'b0;
  endtask

  task automatic drain_expect(input int vals[$]);
    rdy = 1'b1;
    foreach (vals[i]) begin
      int w = 0;
      while (!o_valid && w < 8) begin tick(); w++; end
      check("drain_valid", o_valid, 1);
      check("drain_sample", o_sample, vals[i]);
      tick();
    end
    check("drain_empty", o_valid, 0);
  endtask

  typedef struct {
    int val;
    int n;
    bit fe_sep;
    int exp_sample;
    bit exp_clip;
    bit exp_cnt;
  } vec_t;

  vec_t vt[$];
  int   exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vt.push_back('{1000,   16, 1'b1, 1000,   1'b0, 1'b0});
    vt.push_back('{-1,     16, 1'b0, -1,     1'b0, 1'b0});
    vt.push_back('{-32768, 16, 1'b0, -32768, 1'b0, 1'b0});
    vt.push_back('{32767,  16, 1'b1, 32767,  1'b0, 1'b0});
    vt.push_back('{-8,     16, 1'b1, -8,     1'b0, 1'b0});
    vt.push_back('{100,    15, 1'b1, 93,     1'b0, 1'b1});
    vt.push_back('{-100,   15, 1'b0, -94,    1'b0, 1'b1});
    vt.push_back('{32767,  17, 1'b0, 32767,  1'b1, 1'b1});
    vt.push_back('{-32768, 17, 1'b1, -32768, 1'b1, 1'b1});
    vt.push_back('{7,      17, 1'b0, 7,      1'b0, 1'b1});
    vt.push_back('{0,       0, 1'b1, 0,      1'b0, 1'b1});
    vt.push_back('{15,      1, 1'b0, 0,      1'b0, 1'b1});
    vt.push_back('{-1,      1, 1'b0, -1,     1'b0, 1'b1});

    rst = 1'b1; sub = '0; sub_v = 1'b0; fe = 1'b0; rdy = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_sample", o_sample, 0);
    check("rst_level", o_level, 0);
    check("rst_clip", o_clip, 0);
    check("rst_ovr", o_ovr, 0);
    check("rst_cnt", o_cnt, 0);
    check("rst_s0_valid", s0_valid, 0);
    rst = 1'b0;

    // Table: one frame per row, exact latency and flag outcome.
    foreach (vt[i]) begin
      pulse_clear();
      run_frame(vt[i].n, vt[i].fe_sep, 1'b0, vt[i].val, -1);
      check("tbl_n1_valid", o_valid, 0);
      tick();
      check("tbl_n2_valid", o_valid, 1);
      check("tbl_sample", o_sample, vt[i].exp_sample);
      check("tbl_clip", o_clip, vt[i].exp_clip);
      check("tbl_cnt", o_cnt, vt[i].exp_cnt);
      tick();
      check("tbl_n3_valid", o_valid, 0);
    end

    // Unshifted instance saturates; clear drops the flag next cycle.
    pulse_clear();
    run_frame(16, 1'b0, 1'b0, 30000, -1);
    check("s0_clip_set", s0_clip, 1);
    tick();
    check("s0_valid", s0_valid, 1);
    check("s0_sample", s0_sample, 32767);
    check("s0_default_clip", o_clip, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("s0_clip_cleared", s0_clip, 0);

    // Backpressure: four frames queue, the fifth is dropped.
    pulse_clear();
    rdy = 1'b0;
    for (int k = 1; k <= 5; k++) run_frame(16, 1'b0, 1'b0, k, -1);
    tick(); tick();
    check("bp_level", o_level, 4);
    check("bp_overrun", o_ovr, 1);
    exp_q = {1, 2, 3, 4};
    drain_expect(exp_q);

    // Push into a full queue in the same cycle as a pop is accepted.
    pulse_clear();
    rdy = 1'b0;
    for (int k = 1; k <= 5; k++) run_frame(16, 1'b0, 1'b0, k, -1);
    rdy = 1'b0;
    exp_q = {2, 3, 4, 5};
    check("pf_level_before", o_level, 4);
    check("pf_overrun_before", o_ovr, 0);
    rdy = 1'b1; tick(); rdy = 1'b0;
    check("pf_level", o_level, 4);
    check("pf_overrun", o_ovr, 0);
    drain_expect(exp_q);

    // Count error stays latched across a following correct frame.
    pulse_clear();
    run_frame(15, 1'b1, 1'b0, 100, -1);
    tick(); tick();
    check("ce_set", o_cnt, 1);
    run_frame(16, 1'b0, 1'b0, 100, -1);
    tick();
    check("ce_next_sample", o_sample, 100);
    check("ce_latched", o_cnt, 1);
    tick();

    // Reset mid-frame discards the partial sum.
    pulse_clear();
    sub = 16'sd5000; sub_v = 1'b1;
    repeat (8) tick();
    sub_v = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mr_no_output", o_valid, 0);
      tick();
    end
    run_frame(16, 1'b0, 1'b0, 10, -1);
    tick();
    check("mr_sample", o_sample, 10);
    check("mr_clip", o_clip, 0);
    check("mr_ovr", o_ovr, 0);
    check("mr_cnt", o_cnt, 0);
    tick();
    check("mr_level", o_level, 0);

    // Random frames, light backpressure.
    for (int f = 0; f < 40; f++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 18)) : NV;
      run_frame(n, 1'($urandom_range(0, 1)), 1'b1, 0, 75);
      repeat ($urandom_range(0, 2)) begin
        rdy = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 15) == 0);
        tick();
      end
      clr = 1'b0;
    end

    // Random short frames, heavy backpressure: overruns and pop/push collisions.
    for (int f = 0; f < 30; f++) begin
      int  n;
      bit  sep;
      n   = int'($urandom_range(0, 3));
      sep = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_frame(n, sep, 1'b1, 0, 20);
      if ($urandom_range(0, 9) == 0) begin
        clr = 1'b1; tick(); clr = 1'b0;
      end
    end

    rdy = 1'b1;
    repeat (10) tick();
    check("final_empty", o_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
